// File: rtl/adder_arbiter.sv
// Two-requester arbiter in front of one shared ripple-carry adder.
// Results come back on a single registered response channel tagged with the winning requester.
module adder_arbiter #(
    parameter int WIDTH    = 32,
    parameter bit ARB_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             rr_last_r;
    logic             id_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic [WIDTH-1:0] rsp_sum_r;
    logic             busy_r;
    logic             grant0_s;
    logic             grant1_s;
    logic [WIDTH-1:0] sum_s;

    // Chain of full adders; the final carry-out is intentionally dropped (mod 2^WIDTH).
    function automatic logic [WIDTH-1:0] fa_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic             c;
        logic [WIDTH-1:0] s;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return s;
    endfunction

    assign sum_s = fa_add(a_r, b_r);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant0_s || grant1_s) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: state_next_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Arbitration and combinational ready outputs; rr_last=1 means req0 is favoured next
    always_comb begin
        grant0_s   = req0_valid & (~req1_valid | (ARB_MODE == 1'b1) | rr_last_r);
        grant1_s   = req1_valid & ~grant0_s;
        req0_ready = (state_r == IDLE) & grant0_s;
        req1_ready = (state_r == IDLE) & grant1_s;
    end

    // Operand capture, response registers and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_r   <= 1'b1;
            id_r        <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_sum_r   <= '0;
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (grant0_s || grant1_s) begin
                        a_r       <= grant1_s ? req1_a : req0_a;
                        b_r       <= grant1_s ? req1_b : req0_b;
                        id_r      <= grant1_s;
                        rr_last_r <= grant1_s;
                    end
                end
                CALC: begin
                    rsp_sum_r   <= sum_s;
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_sum   = rsp_sum_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: instance 0 runs round-robin, instance 1 fixed priority.
// Stimulus pushes hand-computed {id,sum} expectations; a negedge monitor pops on each response handshake.
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_valid[2];
    logic        r1_valid[2];
    logic        r0_ready[2];
    logic        r1_ready[2];
    logic [31:0] r0_a[2];
    logic [31:0] r0_b[2];
    logic [31:0] r1_a[2];
    logic [31:0] r1_b[2];
    logic        rsp_valid[2];
    logic        rsp_ready[2];
    logic        rsp_id[2];
    logic [31:0] rsp_sum[2];
    logic        busy[2];

    int          total = 0;
    int          bad = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(32), .ARB_MODE(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0_valid[0]), .req0_ready(r0_ready[0]), .req0_a(r0_a[0]), .req0_b(r0_b[0]),
        .req1_valid(r1_valid[0]), .req1_ready(r1_ready[0]), .req1_a(r1_a[0]), .req1_b(r1_b[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]),
        .rsp_sum(rsp_sum[0]), .busy(busy[0])
    );

    adder_arbiter #(.WIDTH(32), .ARB_MODE(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0_valid[1]), .req0_ready(r0_ready[1]), .req0_a(r0_a[1]), .req0_b(r0_b[1]),
        .req1_valid(r1_valid[1]), .req1_ready(r1_ready[1]), .req1_a(r1_a[1]), .req1_b(r1_b[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]),
        .rsp_sum(rsp_sum[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic id, input logic [31:0] sum);
        if (d == 0) q0.push_back({id, sum});
        else        q1.push_back({id, sum});
    endtask

    task automatic pop_cmp(input int d);
        logic [32:0] e;
        logic        got;
        got = 1'b0;
        e   = '0;
        if (d == 0 && q0.size() > 0) begin
            e = q0.pop_front(); got = 1'b1;
        end else if (d == 1 && q1.size() > 0) begin
            e = q1.pop_front(); got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL unexpected_rsp dut%0d: id=%0d sum=%0h, none expected", d, rsp_id[d], rsp_sum[d]);
        end else begin
            chk($sformatf("rsp_id dut%0d", d), {63'd0, rsp_id[d]}, {63'd0, e[32]});
            chk($sformatf("rsp_sum dut%0d", d), {32'd0, rsp_sum[d]}, {32'd0, e[31:0]});
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && rsp_valid[d] && rsp_ready[d]) pop_cmp(d);
        end
    end

    task automatic set_req(input int d, input logic id, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (!id) begin
            r0_valid[d] = v; r0_a[d] = a; r0_b[d] = b;
        end else begin
            r1_valid[d] = v; r1_a[d] = a; r1_b[d] = b;
        end
    endtask

    function automatic logic rdy(input int d, input logic id);
        return id ? r1_ready[d] : r0_ready[d];
    endfunction

    task automatic wait_any(input int d, output logic ok);
        int n;
        n = 0;
        while (!(r0_ready[d] || r1_ready[d]) && n < 30) begin
            @(negedge clk); #1; n++;
        end
        ok = r0_ready[d] || r1_ready[d];
        if (!ok) begin
            total++; bad++;
            $display("FAIL ready_timeout dut%0d: got no ready, required one", d);
        end
    endtask

    task automatic send(input int d, input logic id, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        n = 0;
        set_req(d, id, 1'b1, a, b);
        #1;
        while (!rdy(d, id) && n < 30) begin
            @(negedge clk); #1; n++;
        end
        if (!rdy(d, id)) begin
            total++; bad++;
            $display("FAIL send_timeout dut%0d id%0d: ready=0 required 1", d, id);
        end else begin
            push(d, id, exp);
            @(posedge clk); #1;
        end
        set_req(d, id, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (((d == 0) ? q0.size() : q1.size()) > 0 && n < 50) begin
            @(negedge clk); n++;
        end
        chk($sformatf("drain dut%0d", d), 64'((d == 0) ? q0.size() : q1.size()), 64'd0);
    endtask

    task automatic do_reset();
        for (int d = 0; d < 2; d++) begin
            set_req(d, 1'b0, 1'b0, 32'd0, 32'd0);
            set_req(d, 1'b1, 1'b0, 32'd0, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va0[2];
        logic [31:0] vb0[2];
        logic [31:0] vs0[2];
        logic [31:0] va1[2];
        logic [31:0] vb1[2];
        logic [31:0] vs1[2];
        logic [31:0] fa[4];
        logic [31:0] fs[4];
        logic        ok;
        logic        id;
        int          i0;
        int          i1;

        va0[0] = 32'h1;    vb0[0] = 32'h2;    vs0[0] = 32'h3;
        va0[1] = 32'h10;   vb0[1] = 32'h20;   vs0[1] = 32'h30;
        va1[0] = 32'h100;  vb1[0] = 32'h200;  vs1[0] = 32'h300;
        va1[1] = 32'h1000; vb1[1] = 32'h1;    vs1[1] = 32'h1001;
        fa[0] = 32'h5; fa[1] = 32'h6; fa[2] = 32'h7; fa[3] = 32'h8;
        fs[0] = 32'h15; fs[1] = 32'h16; fs[2] = 32'h17; fs[3] = 32'h18;

        for (int d = 0; d < 2; d++) begin
            set_req(d, 1'b0, 1'b0, 32'd0, 32'd0);
            set_req(d, 1'b1, 1'b0, 32'd0, 32'd0);
            rsp_ready[d] = 1'b1;
        end
        rst_n = 1'b0;
        #12;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset rsp_valid dut%0d", d), {63'd0, rsp_valid[d]}, 64'd0);
            chk($sformatf("reset rsp_id dut%0d", d), {63'd0, rsp_id[d]}, 64'd0);
            chk($sformatf("reset rsp_sum dut%0d", d), {32'd0, rsp_sum[d]}, 64'd0);
            chk($sformatf("reset busy dut%0d", d), {63'd0, busy[d]}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single request and its latency
        set_req(0, 1'b0, 1'b1, 32'h00000100, 32'h4);
        #1;
        chk("t1 req0_ready", {63'd0, r0_ready[0]}, 64'd1);
        chk("t1 req1_ready", {63'd0, r1_ready[0]}, 64'd0);
        push(0, 1'b0, 32'h00000104);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("t1 calc rsp_valid", {63'd0, rsp_valid[0]}, 64'd0);
        chk("t1 calc busy", {63'd0, busy[0]}, 64'd1);
        @(posedge clk); #1;
        chk("t1 resp rsp_valid", {63'd0, rsp_valid[0]}, 64'd1);
        chk("t1 resp rsp_sum", {32'd0, rsp_sum[0]}, 64'h104);
        drain(0);

        // 2: round-robin with both requesters continuously valid
        do_reset();
        i0 = 0; i1 = 0;
        set_req(0, 1'b0, 1'b1, va0[0], vb0[0]);
        set_req(0, 1'b1, 1'b1, va1[0], vb1[0]);
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_any(0, ok);
            if (ok) begin
                chk("t2 one_ready", {63'd0, r0_ready[0] & r1_ready[0]}, 64'd0);
                id = r1_ready[0];
                chk("t2 rr_order", {63'd0, id}, 64'(k % 2));
                if (!id) push(0, 1'b0, vs0[i0]);
                else     push(0, 1'b1, vs1[i1]);
                @(posedge clk); #1;
                if (!id) begin
                    i0++;
                    if (i0 < 2) set_req(0, 1'b0, 1'b1, va0[i0], vb0[i0]);
                end else begin
                    i1++;
                    if (i1 < 2) set_req(0, 1'b1, 1'b1, va1[i1], vb1[i1]);
                end
            end
        end
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(0, 1'b1, 1'b0, 32'd0, 32'd0);
        drain(0);

        // 3: fixed priority starves req1 until req0 drops
        do_reset();
        set_req(1, 1'b1, 1'b1, 32'h20, 32'h22);
        set_req(1, 1'b0, 1'b1, fa[0], 32'h10);
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_any(1, ok);
            if (ok) begin
                chk("t3 req1_ready", {63'd0, r1_ready[1]}, 64'd0);
                chk("t3 req0_ready", {63'd0, r0_ready[1]}, 64'd1);
                push(1, 1'b0, fs[k]);
                @(posedge clk); #1;
                if (k < 3) set_req(1, 1'b0, 1'b1, fa[k + 1], 32'h10);
            end
        end
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        send(1, 1'b1, 32'h20, 32'h22, 32'h42);
        drain(1);

        // 4: wrap-around and two's complement offset
        send(0, 1'b1, 32'hFFFFFFFC, 32'h00000008, 32'h00000004);
        send(0, 1'b1, 32'h00001000, 32'hFFFFFFF0, 32'h00000FF0);
        drain(0);

        // 5: backpressure holds the response stable
        rsp_ready[0] = 1'b0;
        send(0, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789);
        set_req(0, 1'b1, 1'b1, 32'h7, 32'h8);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            chk("t5 hold rsp_valid", {63'd0, rsp_valid[0]}, 64'd1);
            chk("t5 hold rsp_sum", {32'd0, rsp_sum[0]}, 64'h23456789);
            chk("t5 hold rsp_id", {63'd0, rsp_id[0]}, 64'd0);
            chk("t5 hold ready", {62'd0, r0_ready[0], r1_ready[0]}, 64'd0);
            chk("t5 hold busy", {63'd0, busy[0]}, 64'd1);
            @(posedge clk); #1;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("t5 idle busy", {63'd0, busy[0]}, 64'd0);
        chk("t5 idle rsp_valid", {63'd0, rsp_valid[0]}, 64'd0);
        chk("t5 idle req1_ready", {63'd0, r1_ready[0]}, 64'd1);
        push(0, 1'b1, 32'hF);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'd0, 32'd0);
        drain(0);

        // 6: async reset during CALC drops the transaction
        do_reset();
        set_req(0, 1'b1, 1'b1, 32'h3, 32'h3);
        set_req(0, 1'b1, 1'b0, 32'h3, 32'h3);
        set_req(0, 1'b0, 1'b1, 32'hA, 32'hB);
        #1;
        chk("t6 req0_ready", {63'd0, r0_ready[0]}, 64'd1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 rst rsp_valid", {63'd0, rsp_valid[0]}, 64'd0);
        chk("t6 rst busy", {63'd0, busy[0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b0, 1'b1, 32'h1, 32'h1);
        set_req(0, 1'b1, 1'b1, 32'h3, 32'h3);
        #1;
        chk("t6 first req0_ready", {63'd0, r0_ready[0]}, 64'd1);
        chk("t6 first req1_ready", {63'd0, r1_ready[0]}, 64'd0);
        push(0, 1'b0, 32'h2);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(0, 1'b1, 1'b0, 32'd0, 32'd0);
        drain(0);

        repeat (6) @(negedge clk);
        chk("final queues empty", 64'(q0.size() + q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
